// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
`else
        S_JAL      = 4'd10
`endif
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Immediate format depends only on the opcode; unknown opcodes default to I.
    function automatic imm_src_e imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp plus instruction fields onto the 3-bit ALUControl code.
// slt/sltu are unsupported and fall back to add.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op_b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type (sub possible) from I-ALU, where bit 30 is immediate.
                    3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle RV32I core: fetch/decode/execute/memory/writeback.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unsupported opcodes and expose IllegalOp.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       sign_flag,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       IllegalOp
`endif
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    branch_taken;

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_IALU:   state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:   state_d = S_TRAP;
`else
                    default:   state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // blt/bge look only at the sign of the subtraction; overflow is deliberately ignored.
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = !Zero;
            3'b100:  branch_taken = sign_flag;
            3'b101:  branch_taken = !sign_flag;
            default: branch_taken = 1'b0;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ImmSrc    = imm_src_of(op);
        alu_op    = ALUOP_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
        IllegalOp = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                // Reset forces FETCH, so this branch also defines the outputs seen during reset.
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ImmSrc    = IMM_I;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_SUB;
                PCWrite = branch_taken;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                ImmSrc    = IMM_I;
                IllegalOp = 1'b1;
            end
`endif
            default: begin
                ImmSrc = IMM_I;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op_b5       (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller; per-cycle output vectors are
// predicted from the state walk of each instruction and checked on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       sign_flag;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       ill_obs;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .sign_flag  (sign_flag),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .IllegalOp  (ill_obs)
`endif
    );

`ifndef CTRL_ILLEGAL_TRAP_EN
    assign ill_obs = 1'b0;
`endif

    typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                  T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_JAL, T_TRAP} tstate_e;

    typedef struct {
        string       tag;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [16:0] obs;
    assign obs = {ill_obs, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    // Expected output vector for a state, using the currently driven inputs.
    function automatic logic [16:0] model(input tstate_e st);
        logic       pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 0, sa = 0, sbs = 0, imm = 0, aop = 0;
        logic [2:0] ac;
        case (st)
            T_FETCH:    begin irw = 1; pcw = 1; sbs = 2'b10; rs = 2'b10; end
            T_DECODE:   begin sa = 2'b01; sbs = 2'b01; end
            T_MEMADR:   begin sa = 2'b10; sbs = 2'b01; end
            T_MEMREAD:  adr = 1;
            T_MEMWB:    begin rs = 2'b01; rw = 1; end
            T_MEMWRITE: begin adr = 1; mw = 1; end
            T_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            T_EXECI:    begin sa = 2'b10; sbs = 2'b01; aop = 2'b10; end
            T_ALUWB:    rw = 1;
            T_BRANCH: begin
                sa = 2'b10; aop = 2'b01;
                case (funct3)
                    3'b000:  pcw = Zero;
                    3'b001:  pcw = ~Zero;
                    3'b100:  pcw = sign_flag;
                    3'b101:  pcw = ~sign_flag;
                    default: pcw = 0;
                endcase
            end
            T_JAL:      begin sa = 2'b01; sbs = 2'b10; pcw = 1; end
            T_TRAP:     ill = 1;
            default:    ;
        endcase
        if (st != T_FETCH && st != T_TRAP) begin
            case (op)
                7'b0100011: imm = 2'b01;
                7'b1100011: imm = 2'b10;
                7'b1101111: imm = 2'b11;
                default:    imm = 2'b00;
            endcase
        end
        case (aop)
            2'b01: ac = 3'b010;
            2'b10: begin
                case (funct3)
                    3'b000:  ac = (op == 7'b0110011 && funct7b5) ? 3'b010 : 3'b000;
                    3'b001:  ac = 3'b001;
                    3'b100:  ac = 3'b100;
                    3'b101:  ac = 3'b101;
                    3'b110:  ac = 3'b110;
                    3'b111:  ac = 3'b111;
                    default: ac = 3'b000;
                endcase
            end
            default: ac = 3'b000;
        endcase
        return {ill, pcw, adr, mw, irw, rw, rs, sa, sbs, imm, ac};
    endfunction

    task automatic push(input string name, input tstate_e st);
        exp_t e;
        e.tag = $sformatf("%s/%s", name, st.name());
        e.v   = model(st);
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
        end
    endtask

    // Inputs change just after a rising edge; outputs are compared on the falling edge.
    task automatic drain();
        while (sb.size() > 0) begin
            @(negedge clk);
            check_now();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic z, input logic s);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; sign_flag = s;
    endtask

    task automatic issue(input string name, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z, input logic s);
        set_in(o, f3, f7, z, s);
        push(name, T_FETCH);
        push(name, T_DECODE);
        case (o)
            7'b0000011: begin push(name, T_MEMADR); push(name, T_MEMREAD); push(name, T_MEMWB); end
            7'b0100011: begin push(name, T_MEMADR); push(name, T_MEMWRITE); end
            7'b0110011: begin push(name, T_EXECR); push(name, T_ALUWB); end
            7'b0010011: begin push(name, T_EXECI); push(name, T_ALUWB); end
            7'b1100011: push(name, T_BRANCH);
            7'b1101111: begin push(name, T_JAL); push(name, T_ALUWB); end
            default: ;
        endcase
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        repeat (3) push("reset_hold", T_FETCH);
        drain();
        rst_n = 1'b1;

        issue("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        issue("sub",      7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
        issue("add",      7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        issue("addi_b30", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
        issue("srli",     7'b0010011, 3'b101, 1'b0, 1'b0, 1'b0);
        issue("and",      7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0);
        issue("beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0);
        issue("beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0);
        issue("bne_z1",   7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0);
        issue("blt_s1",   7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1);
        issue("bge_s1",   7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1);
        issue("br_f010",  7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1);
        issue("sw",       7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        issue("jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
`ifndef CTRL_ILLEGAL_TRAP_EN
        issue("lui_nop",  7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
`endif
        issue("xor",      7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of EXECR must abort before writeback.
        set_in(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        push("rtype_abort", T_FETCH);
        push("rtype_abort", T_DECODE);
        drain();
        push("rtype_abort", T_EXECR);
        @(negedge clk);
        check_now();
        #2 rst_n = 1'b0;
        #1;
        push("async_rst", T_FETCH);
        check_now();
        @(posedge clk);
        #1;
        push("async_rst_held", T_FETCH);
        drain();
        rst_n = 1'b1;
        issue("after_rst", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);

        set_in(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        push("illegal", T_FETCH);
        push("illegal", T_DECODE);
`ifdef CTRL_ILLEGAL_TRAP_EN
        repeat (11) push("illegal", T_TRAP);
`else
        push("illegal", T_FETCH);
        push("illegal", T_DECODE);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
